// File: rtl/irq_controller_pkg.sv
// Register offsets, gateway state encodings and address decode helper for irq_controller.
// Shared by irq_gateway and irq_controller; optional edge support is gated by IRQ_EDGE_EN.
package irq_controller_pkg;

  localparam logic [3:0] IRQ_PENDING   = 4'h0;
  localparam logic [3:0] IRQ_ENABLE    = 4'h4;
  localparam logic [3:0] IRQ_CLAIM     = 4'h8;
  localparam logic [3:0] IRQ_EDGE_MODE = 4'hC;

  typedef enum logic [1:0] {
    GW_IDLE = 2'b00,
    GW_PEND = 2'b01,
    GW_SERV = 2'b10
  } gw_state_e;

  // Word-aligned decode: byte-lane bits [1:0] never participate.
  function automatic logic is_reg(input logic [3:0] addr, input logic [3:0] off);
    return addr[3:2] == off[3:2];
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: IDLE -> PEND on request, PEND -> SERV on claim, SERV -> IDLE on complete.
// Pending is visible one cycle after the request; edge mode (IRQ_EDGE_EN) adds a rise detector and "again" flag.
module irq_gateway
  import irq_controller_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  gw_state_e state_q, state_d;
  logic      trig;

`ifdef IRQ_EDGE_EN
  logic prev_q;
  logic again_q, again_d;
  logic rise;

  assign rise = src & ~prev_q;
  assign trig = edge_mode ? (rise | again_q) : src;

  // A rise that arrives while busy is remembered once and replayed on return to IDLE.
  always_comb begin
    again_d = again_q;
    if (state_q == GW_IDLE) begin
      if (trig) again_d = 1'b0;
    end else if (edge_mode && rise) begin
      again_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      again_q <= 1'b0;
    end else begin
      prev_q  <= src;
      again_q <= again_d;
    end
  end
`else
  logic unused_edge_mode;
  assign unused_edge_mode = edge_mode;
  assign trig = src;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      GW_IDLE: if (trig)     state_d = GW_PEND;
      GW_PEND: if (claim)    state_d = GW_SERV;
      GW_SERV: if (complete) state_d = GW_IDLE;
      default:               state_d = GW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= GW_IDLE;
    else     state_q <= state_d;
  end

  assign pending = (state_q == GW_PEND);

endmodule

// File: rtl/irq_controller.sv
// MMIO interrupt controller: per-source gateways, enables, lowest-ID claim/complete; 1-cycle read latency.
// No backpressure: accesses complete in the cycle presented; EDGE_MODE is writable only with IRQ_EDGE_EN.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             mmio_sel,
  input  logic             mmio_read,
  input  logic             mmio_write,
  input  logic [3:0]       mmio_addr,
  input  logic [31:0]      mmio_wdata,
  output logic [31:0]      mmio_rdata,
  output logic             external_int
);

  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] edge_mode;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] claim_vec;
  logic [N_SRC-1:0] complete_vec;
  logic [31:0]      claim_id;
  logic [31:0]      rdata_q, rdata_d;
  logic             ext_int_q;
  logic             rd_en, wr_en;
  logic [1:0]       unused_addr;

  assign unused_addr = mmio_addr[1:0];

  // A combined read+write strobe is a write; the read side is suppressed.
  assign wr_en = mmio_sel & mmio_write;
  assign rd_en = mmio_sel & mmio_read & ~mmio_write;

  always_comb begin
    claim_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend[i] && enable_q[i]) claim_id = 32'(i + 1);
    end
  end

  // Completing a source that is not in SERV is dropped inside its gateway.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_vec[i]    = rd_en && is_reg(mmio_addr, IRQ_CLAIM) && (claim_id == 32'(i + 1));
      complete_vec[i] = wr_en && is_reg(mmio_addr, IRQ_CLAIM) && (mmio_wdata == 32'(i + 1));
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk       (clk),
      .rst       (rst),
      .src       (src_irq[g]),
      .edge_mode (edge_mode[g]),
      .claim     (claim_vec[g]),
      .complete  (complete_vec[g]),
      .pending   (pend[g])
    );
  end

`ifdef IRQ_EDGE_EN
  logic [N_SRC-1:0] edge_mode_q;

  always_ff @(posedge clk) begin
    if (rst) edge_mode_q <= '0;
    else if (wr_en && is_reg(mmio_addr, IRQ_EDGE_MODE)) edge_mode_q <= mmio_wdata[N_SRC-1:0];
  end

  assign edge_mode = edge_mode_q;
`else
  assign edge_mode = '0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      if (is_reg(mmio_addr, IRQ_PENDING))        rdata_d[N_SRC-1:0] = pend;
      else if (is_reg(mmio_addr, IRQ_ENABLE))    rdata_d[N_SRC-1:0] = enable_q;
      else if (is_reg(mmio_addr, IRQ_CLAIM))     rdata_d            = claim_id;
      else if (is_reg(mmio_addr, IRQ_EDGE_MODE)) rdata_d[N_SRC-1:0] = edge_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q  <= '0;
      rdata_q   <= '0;
      ext_int_q <= 1'b0;
    end else begin
      if (wr_en && is_reg(mmio_addr, IRQ_ENABLE)) enable_q <= mmio_wdata[N_SRC-1:0];
      rdata_q   <= rdata_d;
      ext_int_q <= |(pend & enable_q);
    end
  end

  assign mmio_rdata   = rdata_q;
  assign external_int = ext_int_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: read expectations go through a queue checked by a monitor.
// Builds with or without IRQ_EDGE_EN; the edge-mode expectations follow the macro.
module tb_irq_controller;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_irq;
  logic          mmio_sel, mmio_read, mmio_write;
  logic [3:0]    mmio_addr;
  logic [31:0]   mmio_wdata;
  logic [31:0]   mmio_rdata;
  logic          external_int;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [31:0]   exp_q[$];
  string         name_q[$];
  logic [31:0]   last_rd = '0;

`ifdef IRQ_EDGE_EN
  localparam logic [31:0] EDGE_RD  = 32'h1;
  localparam logic [31:0] REPEND_ID = 32'h1;
`else
  localparam logic [31:0] EDGE_RD  = 32'h0;
  localparam logic [31:0] REPEND_ID = 32'h0;
`endif

  irq_controller #(.N_SRC(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_irq      (src_irq),
    .mmio_sel     (mmio_sel),
    .mmio_read    (mmio_read),
    .mmio_write   (mmio_write),
    .mmio_addr    (mmio_addr),
    .mmio_wdata   (mmio_wdata),
    .mmio_rdata   (mmio_rdata),
    .external_int (external_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    mmio_sel  = 1'b1;
    mmio_read = 1'b1;
    mmio_addr = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    last_rd = e;
    @(negedge clk);
    mmio_sel  = 1'b0;
    mmio_read = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    mmio_sel   = 1'b1;
    mmio_write = 1'b1;
    mmio_addr  = a;
    mmio_wdata = d;
    @(negedge clk);
    mmio_sel   = 1'b0;
    mmio_write = 1'b0;
  endtask

  // Monitor: a read accepted at a posedge presents its data right after that edge.
  initial begin
    logic [31:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      if (!rst && mmio_sel && mmio_read && !mmio_write) begin
        #1;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_read: got 0x%0h, expected no read response", mmio_rdata);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, mmio_rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; src_irq = '0;
    mmio_sel = 1'b0; mmio_read = 1'b0; mmio_write = 1'b0;
    mmio_addr = '0; mmio_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_rdata", mmio_rdata, 32'h0);
    check("rst_ext", {31'h0, external_int}, 32'h0);
    rd(4'h0, 32'h0, "rst_pending");
    rd(4'h4, 32'h0, "rst_enable");
    rd(4'h8, 32'h0, "rst_claim");

    // Single source: interrupt line timing around a claim
    wr(4'h4, 32'h05);
    src_irq = 8'h04;
    @(negedge clk);
    check("ext_lag", {31'h0, external_int}, 32'h0);
    @(negedge clk);
    check("ext_rise", {31'h0, external_int}, 32'h1);
    rd(4'h8, 32'h3, "claim3");
    check("ext_hold", {31'h0, external_int}, 32'h1);
    @(negedge clk);
    check("ext_fall", {31'h0, external_int}, 32'h0);
    src_irq = 8'h00;
    wr(4'h8, 32'h3);

    // Two sources, sticky pending, priority order
    wr(4'h4, 32'h06);
    src_irq = 8'h06;
    @(negedge clk);
    src_irq = 8'h00;
    rd(4'h8, 32'h2, "claim_prio_2");
    rd(4'h8, 32'h3, "claim_prio_3");
    rd(4'h8, 32'h0, "claim_prio_none");

    // Disabled source stays pending but is not claimable
    src_irq = 8'h01;
    @(negedge clk);
    src_irq = 8'h00;
    rd(4'h8, 32'h0, "claim_disabled");
    check("ext_disabled", {31'h0, external_int}, 32'h0);
    wr(4'h8, 32'h2);
    wr(4'h8, 32'h3);
    rd(4'h0, 32'h01, "pending_disabled");

    // Held level re-pends after completion
    src_irq = 8'h04;
    @(negedge clk);
    rd(4'h8, 32'h3, "claim_held");
    wr(4'h8, 32'h3);
    rd(4'h0, 32'h01, "repend_1cyc");
    rd(4'h0, 32'h05, "repend_2cyc");
    rd(4'h8, 32'h3, "reclaim3");
    src_irq = 8'h00;

    // Ignored completes
    wr(4'h8, 32'h0);
    wr(4'h8, 32'h9);
    wr(4'h8, 32'h5);
    rd(4'h0, 32'h01, "pend_nochange");
    rd(4'h4, 32'h06, "en_nochange");
    rd(4'h8, 32'h0, "claim_nochange");
    wr(4'h8, 32'h3);

    // Read+write together acts as a write only
    mmio_sel = 1'b1; mmio_read = 1'b1; mmio_write = 1'b1;
    mmio_addr = 4'h4; mmio_wdata = 32'hFF;
    @(negedge clk);
    mmio_sel = 1'b0; mmio_read = 1'b0; mmio_write = 1'b0;
    check("rw_rdata_hold", mmio_rdata, last_rd);
    @(negedge clk);
    check("ext_after_enable", {31'h0, external_int}, 32'h1);
    rd(4'h4, 32'hFF, "en_rw");
    wr(4'h4, 32'hFFFF_FFFF);
    rd(4'h7, 32'hFF, "en_upper_bits");
    rd(4'h8, 32'h1, "claim1");
    wr(4'h8, 32'h1);

    // Edge mode (level fallback when the feature is absent)
    wr(4'hC, 32'h01);
    rd(4'hC, EDGE_RD, "edge_mode_rd");
    wr(4'h4, 32'h01);
    src_irq = 8'h01;
    @(negedge clk);
    src_irq = 8'h00;
    @(negedge clk);
    src_irq = 8'h01;
    @(negedge clk);
    src_irq = 8'h00;
    rd(4'h8, 32'h1, "edge_claim1");
    wr(4'h8, 32'h1);
    @(negedge clk);
    rd(4'h8, REPEND_ID, "edge_repend");
`ifdef IRQ_EDGE_EN
    wr(4'h8, 32'h1);
`endif
    repeat (2) @(negedge clk);
    rd(4'h8, 32'h0, "edge_idle");

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL read_queue_drain: got %0d outstanding, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller.
- Sits on the data-memory side of the core and drives the core's `external_int` input.
- Gathers up to N_SRC peripheral interrupt lines and gates them through per-source enables.
- Software uses a claim/complete register pair to take and retire interrupts.

Parameters:
- N_SRC, 8, number of interrupt sources (1..31); source IDs are 1..N_SRC, and ID 0 means "none".

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- src_irq  input  N_SRC  level interrupt requests; bit i is source ID i+1.
- mmio_sel  input  1  access targets this block this cycle.
- mmio_read  input  1  read strobe; valid only with mmio_sel.
- mmio_write  input  1  write strobe; valid only with mmio_sel.
- mmio_addr  input  4  byte offset; bits [1:0] ignored (word access only).
- mmio_wdata  input  32  write data.
- mmio_rdata  output  32  registered read data.
- external_int  output  1  registered interrupt request to the core.

Behaviour:
- Register map:
  - 0x0 PENDING: RO; bit i = source i+1 pending.
  - 0x4 ENABLE: RW; bits [N_SRC-1:0]; upper bits read 0.
  - 0x8 CLAIM/COMPLETE:
    - Read returns the lowest pending&enabled ID, or 0 if none.
    - Write of an ID completes that source.
  - 0xC EDGE_MODE: see Optional Feature.
  - Unmapped offsets read 0; writes to them are ignored.
- Read latency: mmio_rdata is valid exactly 1 cycle after the mmio_sel&mmio_read cycle; it holds its value otherwise.
- Simultaneous mmio_read&mmio_write: treat as a write only; mmio_rdata is unchanged.
- Per-source gateway FSM, 2-bit state:
  - IDLE -> PEND when src_irq is high.
  - PEND -> SERV when claimed (a CLAIM read returns this ID).
  - SERV -> IDLE when a COMPLETE write carries this ID.
  - In SERV, src_irq is ignored.
  - After returning to IDLE, a still-high level re-pends on the next cycle.
- PEND does not drop if src_irq deasserts; pending is sticky until claimed.
- Claim selection is fixed priority, lowest ID wins. A disabled pending source stays PEND and is not claimable.
- COMPLETE writes with ID 0, ID > N_SRC, or an ID not in SERV are ignored; no state changes.
- Same-cycle events:
  - A claim of source X coincides with src_irq of X: X goes to SERV.
  - A COMPLETE of X coincides with a claim read: the read cannot return X, because X is in SERV during that cycle.
  - An ENABLE write coincides with a claim read: the claim uses the old ENABLE value.
- external_int is registered: the next-cycle value of |(PENDING & ENABLE). It rises 1 cycle after pending becomes visible and falls 1 cycle after the claim.
- Reset values:
  - all gateways IDLE;
  - ENABLE=0, EDGE_MODE=0;
  - mmio_rdata=0, external_int=0.
- Reset mid-operation discards in-service state; no completion is required afterwards.

Optional Feature:
- Macro: IRQ_EDGE_EN.
- Defined:
  - 0xC EDGE_MODE is RW, bits [N_SRC-1:0].
  - An edge-mode source enters PEND on a 0->1 transition of src_irq. A per-source registered previous value is kept, reset to 0.
  - A rising edge seen while in PEND or SERV is latched into a 1-bit per-source "again" flag. The flag re-pends the source on return to IDLE, then clears.
  - Level-mode sources behave as above.
- Undefined:
  - EDGE_MODE reads 0 and writes are ignored.
  - No edge registers exist; all sources are level-mode.

Decomposition:
- Shared header irq.vh holds:
  - register offsets IRQ_PENDING, IRQ_ENABLE, IRQ_CLAIM, IRQ_EDGE_MODE;
  - gateway state encodings GW_IDLE, GW_PEND, GW_SERV.
- Sub-module irq_gateway, instantiated N_SRC times via generate. Its interface:
  - inputs: clk, rst, src, edge_mode, claim, complete;
  - output: pending.
- Priority encoder and register file live in the top level.

Test Plan:
- After reset: read 0x0/0x4/0x8 -> 0,0,0; external_int=0.
- Write ENABLE=0x05, raise src_irq=0x04 (ID 3) -> external_int=1 two cycles later; CLAIM read -> 3; external_int=0 the following cycle.
- src_irq=0x06 with ENABLE=0x06 -> claims return 2, then 3, then 0.
- Hold ID 3 high in SERV; write COMPLETE=3 -> PENDING bit 2 set 2 cycles after the write; next claim returns 3.
- Write COMPLETE=0, 9, and 5 (5 not in service) -> no state change; PENDING and ENABLE unchanged.
- IRQ_EDGE_EN: EDGE_MODE=0x01; pulse ID 1 twice before completing -> claim 1, complete, re-pend once, claim 1, complete -> then idle.
